// File: rtl/button_event_decoder_pkg.sv
// Shared definitions for the button event decoder: state encoding,
// counter width and default timing for a 50 MHz board clock.
package button_event_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } state_t;

    localparam int unsigned CNT_W = 32;

    // 1 s long-press threshold and 200 ms repeat period at 50 MHz
    localparam int unsigned DEFAULT_LONG_PRESS_CYCLES = 50000000;
    localparam int unsigned DEFAULT_REPEAT_CYCLES     = 10000000;

endpackage

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into registered one-cycle event pulses
// (press, release, long-press, auto-repeat) plus a held level.
module button_event_decoder
    import button_event_decoder_pkg::*;
#(
    parameter int unsigned LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
    parameter int unsigned REPEAT_CYCLES     = DEFAULT_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic button_in,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press_pulse,
    output logic repeat_pulse,
    output logic held
);

    localparam logic [CNT_W-1:0] LP_LAST  = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam bit               REP_EN   = (REPEAT_CYCLES != 0);
    localparam logic [CNT_W-1:0] REP_LAST = REP_EN ? CNT_W'(REPEAT_CYCLES - 1) : '0;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    state_t           w_state_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_press;
    logic             w_release;
    logic             w_long;
    logic             w_repeat;
    logic             w_held;

    // Next-state, counter and event decode; release always wins over a threshold
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_press      = 1'b0;
        w_release    = 1'b0;
        w_long       = 1'b0;
        w_repeat     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (button_in) begin
                    w_state_next = PRESSED;
                    w_cnt_next   = '0;
                    w_press      = 1'b1;
                end
            end
            PRESSED: begin
                if (!button_in) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                    w_release    = 1'b1;
                end else if (r_cnt == LP_LAST) begin
                    w_state_next = LONG_HELD;
                    w_cnt_next   = '0;
                    w_long       = 1'b1;
                end else begin
                    w_cnt_next   = r_cnt + 1'b1;
                end
            end
            LONG_HELD: begin
                if (!button_in) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                    w_release    = 1'b1;
                end else if (REP_EN && (r_cnt == REP_LAST)) begin
                    w_cnt_next   = '0;
                    w_repeat     = 1'b1;
                end else if (r_cnt != '1) begin
                    // Only reachable at all-ones when repeat is disabled; saturate there
                    w_cnt_next   = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
        w_held = (w_state_next != IDLE);
    end

    // State, counter and registered outputs; synchronous reset has priority
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= IDLE;
            r_cnt            <= '0;
            press_pulse      <= 1'b0;
            release_pulse    <= 1'b0;
            long_press_pulse <= 1'b0;
            repeat_pulse     <= 1'b0;
            held             <= 1'b0;
        end else begin
            r_state          <= w_state_next;
            r_cnt            <= w_cnt_next;
            press_pulse      <= w_press;
            release_pulse    <= w_release;
            long_press_pulse <= w_long;
            repeat_pulse     <= w_repeat;
            held             <= w_held;
        end
    end

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench for button_event_decoder: the driver computes the
// expected outputs from the length of the current held run and queues
// them; a monitor pops one entry per clock and compares.
module tb_button_event_decoder;

    localparam int unsigned L = 8;
    localparam int unsigned R = 4;

    logic clk = 1'b0;
    logic reset;
    logic button_in;
    logic press_pulse;
    logic release_pulse;
    logic long_press_pulse;
    logic repeat_pulse;
    logic held;

    always #5 clk = ~clk;

    button_event_decoder #(
        .LONG_PRESS_CYCLES(L),
        .REPEAT_CYCLES    (R)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .button_in       (button_in),
        .press_pulse     (press_pulse),
        .release_pulse   (release_pulse),
        .long_press_pulse(long_press_pulse),
        .repeat_pulse    (repeat_pulse),
        .held            (held)
    );

    // {press, release, long, repeat, held}
    logic [4:0]  exp_q[$];
    int          total   = 0;
    int          bad     = 0;
    bit          started = 1'b0;
    bit          done    = 1'b0;
    int unsigned run     = 0;   // consecutive high samples since the press edge
    int          cyc     = 0;

    // Drive one edge's inputs and queue what that edge must produce
    task automatic step(input logic rst, input logic b);
        logic [4:0] e;
        @(negedge clk);
        reset     = rst;
        button_in = b;
        if (rst) begin
            e   = 5'b0;
            run = 0;
        end else begin
            e[4] = b && (run == 0);
            e[3] = !b && (run > 0);
            e[2] = b && (run == L);
            e[1] = b && (R != 0) && (run > L) && (((run - L) % R) == 0);
            e[0] = b;
            run  = b ? run + 1 : 0;
        end
        exp_q.push_back(e);
        started = 1'b1;
    endtask

    task automatic hold(input logic b, input int n);
        for (int i = 0; i < n; i++) step(1'b0, b);
    endtask

    // Monitor: compare the DUT outputs after every edge against the queue
    initial begin
        logic [4:0] e;
        logic [4:0] act;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            act = {press_pulse, release_pulse, long_press_pulse, repeat_pulse, held};
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                total++;
                if (act !== e) begin
                    bad++;
                    $display("FAIL outputs cycle %0d: got press/rel/long/rep/held=%b expected %b",
                             cyc, act, e);
                end
            end else if (started && !done) begin
                total++;
                bad++;
                $display("FAIL scoreboard cycle %0d: got no expectation, expected one queued", cyc);
            end
        end
    end

    initial begin
        reset     = 1'b1;
        button_in = 1'b0;

        // Reset with button released
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        hold(1'b0, 2);

        // Short press: press, held, release, no long/repeat
        hold(1'b1, 3);
        hold(1'b0, 2);

        // Long hold with repeats; release beats the repeat due at t20
        hold(1'b1, 20);
        hold(1'b0, 2);

        // Release exactly when long-press would fire
        hold(1'b1, 8);
        hold(1'b0, 2);

        // Reset in LONG_HELD with button held through it
        hold(1'b1, 12);
        step(1'b1, 1'b1);
        hold(1'b1, 10);
        hold(1'b0, 2);

        // Back-to-back presses with a single low cycle
        hold(1'b1, 2);
        hold(1'b0, 1);
        hold(1'b1, 1);
        hold(1'b0, 2);

        // Randomized held runs, gaps and occasional resets
        for (int k = 0; k < 60; k++) begin
            int unsigned hi;
            hi = $urandom_range(24, 1);
            for (int unsigned j = 0; j < hi; j++) begin
                if ($urandom_range(29, 0) == 0) step(1'b1, $urandom_range(1, 0) == 1);
                else                            step(1'b0, 1'b1);
            end
            hold(1'b0, $urandom_range(3, 1));
        end

        done = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Consumes the clean, debounced button level produced by the debounce stage and turns it into one-cycle event pulses for the display and control logic.
- Events: press, release, long-press and auto-repeat while held, plus a held level.
- Sits between the debounce stage and the 7-segment control FSM, one instance per button.

Parameters:
- LONG_PRESS_CYCLES, 50000000, cycles a press must last before long_press_pulse fires; must be >= 2.
- REPEAT_CYCLES, 10000000, period of repeat_pulse after a long press; 0 disables repeat.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- button_in  input  1  debounced button level, 1 = pressed; already synchronous to clk.
- press_pulse  output  1  one-cycle pulse on press.
- release_pulse  output  1  one-cycle pulse on release.
- long_press_pulse  output  1  one-cycle pulse when a press reaches LONG_PRESS_CYCLES.
- repeat_pulse  output  1  one-cycle pulse every REPEAT_CYCLES while in long hold.
- held  output  1  level, 1 while the decoder is in any pressed state.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high. Reset has priority over all other inputs.
- On reset: state IDLE, counter 0, all outputs 0.
- All outputs are registered. A pulse is high for exactly one clock period and is never asserted two cycles in a row.
- Counter is 32-bit unsigned and never wraps: it is cleared on every state entry and on each threshold hit.
- States: IDLE, PRESSED, LONG_HELD.
- held = 1 in PRESSED or LONG_HELD, registered, changing on the same edge as the state.
- IDLE:
  - button_in=1 at an edge: go to PRESSED, counter <= 0, press_pulse <= 1.
  - Otherwise stay in IDLE.
  - Entry is level-based, so a button held through reset deassertion produces a press on the first edge after reset.
- PRESSED:
  - button_in=0: release_pulse <= 1, go to IDLE.
  - Else if counter == LONG_PRESS_CYCLES-1: long_press_pulse <= 1, go to LONG_HELD, counter <= 0.
  - Else counter <= counter+1.
  - Net effect: long_press_pulse fires LONG_PRESS_CYCLES edges after the press edge.
- LONG_HELD:
  - button_in=0: release_pulse <= 1, go to IDLE.
  - Else if REPEAT_CYCLES != 0 and counter == REPEAT_CYCLES-1: repeat_pulse <= 1, counter <= 0.
  - Else counter <= counter+1, saturating at all-ones when repeat is disabled.
- Simultaneous events: release beats a threshold on the same edge. No long or repeat pulse is emitted on the release edge.
- Latency: every event is visible one cycle after the edge that samples the causing button_in value.
- Back-to-back presses: a single low cycle between two highs gives release then press on consecutive edges.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=2'd0, PRESSED=2'd1, LONG_HELD=2'd2);
  - the counter width constant (32);
  - default timing constants for a 50 MHz board clock.
- No sub-module is needed. A single FSM with one counter is natural; instantiate it after debounce_circuit at the top level.

Test Plan (LONG_PRESS_CYCLES=8, REPEAT_CYCLES=4; edge t0 = first edge sampling button_in=1):
- Reset with button_in=0 for 3 cycles -> all outputs 0, held 0.
- button_in=1 for edges t0..t2, then 0 -> press_pulse after t0, held 1 for t0..t2, release_pulse after t3, no long/repeat.
- button_in=1 for edges t0..t19, 0 at t20:
  - press after t0, long_press after t8, repeat after t12 and t16;
  - at t20, release_pulse only (release beats the due repeat).
- button_in=1 for edges t0..t7, 0 at t8 -> release_pulse after t8, long_press_pulse never asserted.
- In LONG_HELD, reset=1 for one edge with button_in held 1:
  - all outputs 0 after the reset edge;
  - press_pulse on the first edge after reset deasserts; long_press again 8 edges later.
- Pattern 1,1,0,1 -> press, release, press on the edges sampling the 1st, 3rd and 4th values; held drops for exactly one cycle.
